// File: rtl/mac_arbiter_if.sv
// Request, datapath and response bundle for mac_arbiter.
// master = arbiter view, slave = requesters plus datapath view.
interface mac_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [16*NUM_REQ-1:0] req_c;
    logic [16*NUM_REQ-1:0] req_d;
    logic [16*NUM_REQ-1:0] req_e;

    logic                  dp_in_valid;
    logic                  dp_in_ready;
    logic signed [15:0]    dp_a;
    logic signed [15:0]    dp_b;
    logic signed [15:0]    dp_c;
    logic signed [15:0]    dp_d;
    logic signed [15:0]    dp_e;

    logic                  dp_out_valid;
    logic                  dp_out_ready;
    logic signed [31:0]    dp_y;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic signed [31:0]    rsp_y;

    modport master (
        input  req_valid, req_a, req_b, req_c, req_d, req_e,
        input  dp_in_ready, dp_out_valid, dp_y, rsp_ready,
        output req_ready, dp_in_valid, dp_a, dp_b, dp_c, dp_d, dp_e,
        output dp_out_ready, rsp_valid, rsp_y
    );

    modport slave (
        output req_valid, req_a, req_b, req_c, req_d, req_e,
        output dp_in_ready, dp_out_valid, dp_y, rsp_ready,
        input  req_ready, dp_in_valid, dp_a, dp_b, dp_c, dp_d, dp_e,
        input  dp_out_ready, rsp_valid, rsp_y
    );
endinterface

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one MAC datapath, with in-order tag FIFO for result return.
// Optional performance counters enabled by defining MAC_ARB_PERF_EN.
module mac_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_arbiter_if.master bus,
    output logic          err,
    output logic [31:0]   perf_grants,
    output logic [31:0]   perf_stalls
);
    localparam int unsigned NR = NUM_REQ;
    localparam int RW = $clog2(NUM_REQ);
    localparam int AW = $clog2(MAX_OUT);
    localparam int OW = AW + 1;

    logic [RW-1:0] rr_ptr;
    logic [RW-1:0] win;
    logic          any;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] occ;
    logic [RW-1:0] tags [MAX_OUT];
    logic [RW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          space;

    always_comb begin
        int unsigned idx;
        idx = 0;
        any = 1'b0;
        win = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            idx = {{(32-RW){1'b0}}, rr_ptr} + i;
            if (idx >= NR) idx = idx - NR;
            if (!any && bus.req_valid[idx]) begin
                any = 1'b1;
                win = RW'(idx);
            end
        end
    end

    assign full  = (occ == OW'(MAX_OUT));
    assign empty = (occ == '0);
    assign head  = tags[rd_ptr];

    // A pop frees its slot in the same cycle, so a full FIFO can still accept when draining.
    assign pop   = !empty && bus.dp_out_valid && bus.rsp_ready[head];
    assign space = !full || pop;

    assign bus.dp_in_valid = rst_n && any && space;
    assign push            = bus.dp_in_valid && bus.dp_in_ready;

    always_comb begin
        int unsigned sel;
        sel = {{(32-RW){1'b0}}, win} << 4;
        bus.req_ready = '0;
        if (push) bus.req_ready[win] = 1'b1;
        bus.dp_a = '0;
        bus.dp_b = '0;
        bus.dp_c = '0;
        bus.dp_d = '0;
        bus.dp_e = '0;
        if (any) begin
            bus.dp_a = bus.req_a[sel +: 16];
            bus.dp_b = bus.req_b[sel +: 16];
            bus.dp_c = bus.req_c[sel +: 16];
            bus.dp_d = bus.req_d[sel +: 16];
            bus.dp_e = bus.req_e[sel +: 16];
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (rst_n && !empty && bus.dp_out_valid) bus.rsp_valid[head] = 1'b1;
        bus.rsp_y        = bus.dp_y;
        bus.dp_out_ready = empty ? 1'b1 : bus.rsp_ready[head];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            err    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (win == RW'(NR - 1)) ? '0 : win + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      occ <= occ + 1'b1;
            else if (pop && !push) occ <= occ - 1'b1;
            if (empty && bus.dp_out_valid) err <= 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) tags[wr_ptr] <= win;
    end

`ifdef MAC_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (push) perf_grants <= perf_grants + 1'b1;
            if (bus.dp_in_valid && !bus.dp_in_ready) perf_stalls <= perf_stalls + 1'b1;
        end
    end
`else
    assign perf_grants = '0;
    assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_mac_arbiter.sv
// Directed self-checking bench for mac_arbiter; the bench itself acts as the MAC datapath.
module tb_mac_arbiter;
    localparam int NUM_REQ = 4;
    localparam int MAX_OUT = 4;
`ifdef MAC_ARB_PERF_EN
    localparam int EXP_STALLS = 5;
    localparam int EXP_GRANTS = 1;
`else
    localparam int EXP_STALLS = 0;
    localparam int EXP_GRANTS = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        err;
    logic [31:0] perf_grants;
    logic [31:0] perf_stalls;
    logic        dp_force;

    int n_checks;
    int n_pass;
    int acc_cnt;
    int rsp_any;
    int rsp_cnt [NUM_REQ];
    int glog [$];
    int q [$];

    mac_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mac_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .err         (err),
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Datapath model: records handshakes using pre-edge values.
    always @(posedge clk) begin
        if (bus.dp_in_valid && bus.dp_in_ready) begin
            q.push_back($signed(bus.dp_a) * $signed(bus.dp_b) + $signed(bus.dp_c) * $signed(bus.dp_d)
                        + $signed(bus.dp_e));
            acc_cnt++;
            for (int k = 0; k < NUM_REQ; k++) if (bus.req_ready[k]) glog.push_back(k);
        end
        if (bus.dp_out_valid && bus.dp_out_ready && q.size() != 0) void'(q.pop_front());
        for (int k = 0; k < NUM_REQ; k++) if (bus.rsp_valid[k] && bus.rsp_ready[k]) rsp_cnt[k]++;
        if (|bus.rsp_valid) rsp_any++;
    end

    always @(negedge clk) begin
        #1;
        bus.dp_out_valid = (q.size() != 0) || dp_force;
        bus.dp_y         = (q.size() != 0) ? q[0] : 0;
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_stats;
        acc_cnt = 0;
        rsp_any = 0;
        glog.delete();
        for (int k = 0; k < NUM_REQ; k++) rsp_cnt[k] = 0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0;
        dp_force = 1'b0;
        q.delete();
        tick;
        tick;
        clear_stats;
        rst_n = 1'b1;
    endtask

    task automatic drain;
        for (int n = 0; n < 40 && q.size() != 0; n++) tick;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int order;
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        dp_force = 1'b0;
        bus.req_valid = '1;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_c = '0;
        bus.req_d = '0;
        bus.req_e = '0;
        bus.dp_in_ready = 1'b1;
        bus.rsp_ready = '1;
        bus.dp_out_valid = 1'b0;
        bus.dp_y = '0;
        clear_stats;

        // Reset state
        @(negedge clk);
        #2;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_dp_in_valid", 64'(bus.dp_in_valid), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_perf_grants", 64'(perf_grants), 64'd0);
        check("rst_perf_stalls", 64'(perf_stalls), 64'd0);

        // Single requester 2: 3*4 + 5*6 + 7 = 49
        do_reset;
        bus.req_a[32 +: 16] = 16'd3;
        bus.req_b[32 +: 16] = 16'd4;
        bus.req_c[32 +: 16] = 16'd5;
        bus.req_d[32 +: 16] = 16'd6;
        bus.req_e[32 +: 16] = 16'd7;
        bus.req_valid = 4'b0100;
        #2;
        check("t1_req_ready", 64'(bus.req_ready), 64'h4);
        check("t1_dp_a", 64'(bus.dp_a), 64'd3);
        check("t1_dp_e", 64'(bus.dp_e), 64'd7);
        tick;
        bus.req_valid = '0;
        #2;
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'h4);
        check("t1_rsp_y", 64'(bus.rsp_y), 64'd49);
        check("t1_dp_a_idle", 64'(bus.dp_a), 64'd0);
        tick;
        #2;
        check("t1_rsp_done", 64'(bus.rsp_valid), 64'd0);
        check("t1_accepts", 64'(acc_cnt), 64'd1);

        // All four continuously valid for eight accepts
        do_reset;
        bus.req_valid = '1;
        for (int n = 0; n < 40 && acc_cnt < 8; n++) tick;
        bus.req_valid = '0;
        check("t2_accepts", 64'(acc_cnt), 64'd8);
        order = 0;
        for (int i = 0; i < 8 && i < glog.size(); i++) order |= glog[i] << (4 * i);
        check("t2_order", 64'(order), 64'h32103210);
        drain;
        tick;
        check("t2_rsp_counts", 64'({rsp_cnt[3][3:0], rsp_cnt[2][3:0], rsp_cnt[1][3:0], rsp_cnt[0][3:0]}),
              64'h2222);

        // FIFO fills at MAX_OUT, one slot frees on a pop
        do_reset;
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0001;
        repeat (10) tick;
        check("t3_accepts_full", 64'(acc_cnt), 64'd4);
        #2;
        check("t3_ready_full", 64'(bus.req_ready), 64'd0);
        check("t3_in_valid_full", 64'(bus.dp_in_valid), 64'd0);
        bus.rsp_ready = 4'b0001;
        #2;
        check("t3_ready_on_pop", 64'(bus.req_ready), 64'h1);
        tick;
        bus.rsp_ready = '0;
        repeat (5) tick;
        check("t3_accepts_after", 64'(acc_cnt), 64'd5);
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        drain;

        // Stall with requester 1 pending; rr_ptr already at 1
        do_reset;
        bus.req_valid = 4'b0001;
        tick;
        bus.req_valid = 4'b0011;
        bus.dp_in_ready = 1'b0;
        repeat (5) tick;
        #2;
        check("t4_ready_stalled", 64'(bus.req_ready), 64'd0);
        check("t4_in_valid_stalled", 64'(bus.dp_in_valid), 64'd1);
        check("t4_perf_stalls", 64'(perf_stalls), 64'(EXP_STALLS));
        check("t4_perf_grants", 64'(perf_grants), 64'(EXP_GRANTS));
        bus.dp_in_ready = 1'b1;
        #2;
        check("t4_winner", 64'(bus.req_ready), 64'h2);
        tick;
        bus.req_valid = '0;
        check("t4_accepts", 64'(acc_cnt), 64'd2);
        check("t4_last_grant", 64'((glog.size() != 0) ? glog[glog.size()-1] : -1), 64'd1);
        drain;

        // Stray result with empty FIFO
        do_reset;
        dp_force = 1'b1;
        #2;
        check("t5_out_ready", 64'(bus.dp_out_ready), 64'd1);
        check("t5_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick;
        dp_force = 1'b0;
        #2;
        check("t5_err_set", 64'(err), 64'd1);
        repeat (3) tick;
        check("t5_err_sticky", 64'(err), 64'd1);
        rst_n = 1'b0;
        #2;
        check("t5_err_cleared", 64'(err), 64'd0);

        // Reset with three operations outstanding
        do_reset;
        bus.rsp_ready = '0;
        bus.req_valid = 4'b0001;
        for (int n = 0; n < 20 && acc_cnt < 3; n++) tick;
        bus.req_valid = '0;
        check("t6_accepts", 64'(acc_cnt), 64'd3);
        rst_n = 1'b0;
        #2;
        check("t6_out_ready_rst", 64'(bus.dp_out_ready), 64'd1);
        check("t6_rsp_valid_rst", 64'(bus.rsp_valid), 64'd0);
        rsp_any = 0;
        tick;
        rst_n = 1'b1;
        bus.rsp_ready = '1;
        repeat (6) tick;
        check("t6_late_rsp", 64'(rsp_any), 64'd0);
        check("t6_err", 64'(err), 64'd1);
        check("t6_drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
